mask_row_assembler: RTL

Downstream stage of the mask serializer: it pulls 20-bit mask words through the serializer's `next` request and rebuilds full mask rows for the pixel-array row driver. Row width is 320, 640 or 1080 pixels, selected by `imageResolution`. A completed row is held in an output register with a valid/ack handshake. The next row is assembled behind it, so only one row of skid buffering exists.

---
 rtl/mask_row_assembler.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mask_row_assembler.sv
// Rebuilds full pixel-mask rows from 20-bit serializer words and hands them to
// the row driver through a single output register with a valid/ack handshake.
module mask_row_assembler #(
  parameter int IP_CHANNEL_WIDTH = 20,
  parameter int OP_ROW_WIDTH     = 1080,
  parameter int stepSel0         = 16,
  parameter int stepSel1         = 32,
  parameter int stepSel2         = 54
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [1:0]                  imageResolution,
  input  logic [10:0]                 frame_rows,
  input  logic [IP_CHANNEL_WIDTH-1:0] DIN,
  output logic                        next,
  output logic [0:OP_ROW_WIDTH-1]     row_out,
  output logic                        row_valid,
  output logic [10:0]                 row_idx,
  input  logic                        row_ack,
  output logic                        busy,
  output logic                        frame_done
);

  localparam int MAX_STEPS = OP_ROW_WIDTH / IP_CHANNEL_WIDTH;
  localparam int CNT_W     = $clog2(MAX_STEPS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LAST,
    S_XFER,
    S_TAIL
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [CNT_W-1:0]          r_steps;
  logic [CNT_W-1:0]          r_req_cnt;
  logic [CNT_W-1:0]          r_cap_cnt;
  logic [10:0]               r_frame_rows;
  logic [10:0]               r_rows_done;
  logic                      r_cap_en;
  logic                      r_row_valid;
  logic [10:0]               r_row_idx;
  logic                      r_busy;
  logic                      r_frame_done;
  logic [0:OP_ROW_WIDTH-1]   r_asm;
  logic [0:OP_ROW_WIDTH-1]   r_row_out;

  logic [CNT_W-1:0]          w_steps_sel;
  logic [CNT_W-1:0]          w_last_step;
  logic [10:0]               w_rows_inc;
  logic                      w_start_ok;
  logic                      w_load;
  logic                      w_ack;
  logic                      w_more_rows;
  logic                      w_next;

  always_comb begin
    w_steps_sel = CNT_W'(stepSel2);
    case (imageResolution)
      2'b00:   w_steps_sel = CNT_W'(stepSel0);
      2'b01:   w_steps_sel = CNT_W'(stepSel1);
      default: w_steps_sel = CNT_W'(stepSel2);
    endcase
  end

  assign w_last_step = r_steps - CNT_W'(1);
  assign w_rows_inc  = r_rows_done + 11'd1;
  assign w_start_ok  = (r_state == S_IDLE) && start && (frame_rows != 11'd0);
  // The output register is free when empty or being drained this very cycle.
  assign w_load      = (r_state == S_XFER) && (!r_row_valid || row_ack);
  assign w_ack       = r_row_valid && row_ack;
  assign w_more_rows = (w_rows_inc < r_frame_rows);
  assign w_next      = (r_state == S_FETCH);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_nxt = S_FETCH;
      S_FETCH: if (r_req_cnt == w_last_step) w_state_nxt = S_LAST;
      S_LAST:  w_state_nxt = S_XFER;
      S_XFER:  if (w_load) w_state_nxt = w_more_rows ? S_FETCH : S_TAIL;
      S_TAIL:  if (w_ack) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_steps      <= '0;
      r_req_cnt    <= '0;
      r_cap_cnt    <= '0;
      r_frame_rows <= '0;
      r_rows_done  <= '0;
      r_cap_en     <= 1'b0;
      r_row_valid  <= 1'b0;
      r_row_idx    <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_row_out    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cap_en     <= w_next;
      r_frame_done <= 1'b0;
      if (w_start_ok) begin
        r_steps      <= w_steps_sel;
        r_frame_rows <= frame_rows;
        r_req_cnt    <= '0;
        r_cap_cnt    <= '0;
        r_rows_done  <= '0;
        r_busy       <= 1'b1;
      end
      if (r_state == S_FETCH)
        r_req_cnt <= (r_req_cnt == w_last_step) ? '0 : r_req_cnt + CNT_W'(1);
      // Capture index saturates so the final word lands in the last slot.
      if (r_cap_en && (r_cap_cnt != w_last_step))
        r_cap_cnt <= r_cap_cnt + CNT_W'(1);
      if (w_load) begin
        r_row_out   <= r_asm;
        r_row_valid <= 1'b1;
        r_row_idx   <= r_rows_done;
        r_rows_done <= w_rows_inc;
        if (w_more_rows) r_cap_cnt <= '0;
      end else if (w_ack) begin
        r_row_valid <= 1'b0;
      end
      if ((r_state == S_TAIL) && w_ack) begin
        r_frame_done <= 1'b1;
        r_busy       <= 1'b0;
      end
    end
  end

  // Assembly register: word MSB lands on the lowest pixel of its chunk.
  always_ff @(posedge clk) begin
    if (w_start_ok || (w_load && w_more_rows)) begin
      r_asm <= '0;
    end else if (r_cap_en) begin
      for (int k = 0; k < MAX_STEPS; k++) begin
        if (r_cap_cnt == CNT_W'(k))
          r_asm[k*IP_CHANNEL_WIDTH +: IP_CHANNEL_WIDTH] <= DIN;
      end
    end
  end

  assign next       = w_next;
  assign row_out    = r_row_out;
  assign row_valid  = r_row_valid;
  assign row_idx    = r_row_idx;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule
